// File: rtl/iir_lp_cascade.sv
// Time-multiplexed cascade of N_SECT direct-form-I biquad sections sharing one multiplier-accumulator.
// Define IIR_LP_SAT_EN to clamp section outputs (and raise sticky sat_flag); otherwise outputs wrap.
module iir_lp_cascade #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int N_SECT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        coef_we,
    input  logic [$clog2(5*N_SECT)-1:0] coef_addr,
    input  logic [COEF_W-1:0]           coef_wdata,
    input  logic                        clear_hist,
    output logic                        sat_flag
);
    localparam int N_COEF  = 5 * N_SECT;
    localparam int ADDR_W  = $clog2(N_COEF);
    localparam int ADDR_W1 = ADDR_W + 1;
    localparam int SEC_W   = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ACC_W   = PROD_W + 3;

    localparam logic [SEC_W-1:0]        LAST_SEC = SEC_W'(N_SECT - 1);
    localparam logic [ADDR_W:0]         N_COEF_V = ADDR_W1'(N_COEF);
    localparam logic [COEF_W-1:0]       B0_ONE   = {{(COEF_W-1){1'b0}}, 1'b1} << (COEF_W - 2);
    localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_W - 3);
    localparam logic signed [ACC_W-1:0] Y_MAX    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN    = ~Y_MAX;

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, UPD = 2'd2, OUT = 2'd3} state_t;

    state_t                    state_q, state_d;
    logic [SEC_W-1:0]          sec_q, sec_d;
    logic [2:0]                tap_q, tap_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         cur_x_q, cur_x_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      sat_q, sat_d;
    logic [COEF_W-1:0]         coef_q [N_COEF];
    logic [COEF_W-1:0]         coef_d [N_COEF];
    logic [DATA_W-1:0]         x1_q [N_SECT], x2_q [N_SECT], y1_q [N_SECT], y2_q [N_SECT];
    logic [DATA_W-1:0]         x1_d [N_SECT], x2_d [N_SECT], y1_d [N_SECT], y2_d [N_SECT];

    logic [ADDR_W-1:0]         coef_idx_s;
    logic [COEF_W-1:0]         coef_sel_s;
    logic [DATA_W-1:0]         opnd_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [ACC_W-1:0]   prod_ext_s, rnd_s, shr_s;
    logic [DATA_W-1:0]         y_s;
    logic                      clamp_s;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

    // Shared multiplier operands and the round/narrow of the finished accumulator.
    always_comb begin
        coef_idx_s = ADDR_W'(sec_q) * ADDR_W'(3'd5) + ADDR_W'(tap_q);
        coef_sel_s = coef_q[coef_idx_s];
        opnd_s     = '0;
        case (tap_q)
            3'd0:    opnd_s = cur_x_q;
            3'd1:    opnd_s = x1_q[sec_q];
            3'd2:    opnd_s = x2_q[sec_q];
            3'd3:    opnd_s = y1_q[sec_q];
            3'd4:    opnd_s = y2_q[sec_q];
            default: opnd_s = '0;
        endcase
        prod_s     = $signed({{DATA_W{coef_sel_s[COEF_W-1]}}, coef_sel_s})
                   * $signed({{COEF_W{opnd_s[DATA_W-1]}}, opnd_s});
        prod_ext_s = $signed({{3{prod_s[PROD_W-1]}}, prod_s});
        rnd_s      = acc_q + RND_HALF;
        shr_s      = rnd_s >>> (COEF_W - 2);
        y_s        = DATA_W'(shr_s);
        clamp_s    = 1'b0;
`ifdef IIR_LP_SAT_EN
        if (shr_s > Y_MAX) begin
            y_s     = DATA_W'(Y_MAX);
            clamp_s = 1'b1;
        end else if (shr_s < Y_MIN) begin
            y_s     = DATA_W'(Y_MIN);
            clamp_s = 1'b1;
        end else begin
            y_s     = DATA_W'(shr_s);
            clamp_s = 1'b0;
        end
`endif
    end

    // Sequencer: accept, five MAC taps per section, history update, output hold.
    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        cur_x_d    = cur_x_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        coef_d     = coef_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        case (state_q)
            IDLE: begin
                if (coef_we && ({1'b0, coef_addr} < N_COEF_V)) begin
                    coef_d[coef_addr] = coef_wdata;
                end else begin
                    coef_d = coef_q;
                end
                // Clearing happens in the same cycle as a possible accept, so that sample sees zero history.
                if (clear_hist) begin
                    for (int s = 0; s < N_SECT; s++) begin
                        x1_d[s] = '0;
                        x2_d[s] = '0;
                        y1_d[s] = '0;
                        y2_d[s] = '0;
                    end
                end else begin
                    x1_d = x1_q;
                end
                if (in_valid) begin
                    cur_x_d = in_data;
                    sec_d   = '0;
                    tap_d   = 3'd0;
                    acc_d   = '0;
                    state_d = MAC;
                end else begin
                    state_d = IDLE;
                end
            end
            MAC: begin
                if (tap_q >= 3'd3) begin
                    acc_d = acc_q - prod_ext_s;
                end else begin
                    acc_d = acc_q + prod_ext_s;
                end
                if (tap_q == 3'd4) begin
                    tap_d   = 3'd0;
                    state_d = UPD;
                end else begin
                    tap_d   = tap_q + 3'd1;
                    state_d = MAC;
                end
            end
            UPD: begin
                x2_d[sec_q] = x1_q[sec_q];
                x1_d[sec_q] = cur_x_q;
                y2_d[sec_q] = y1_q[sec_q];
                y1_d[sec_q] = y_s;
                cur_x_d     = y_s;
                acc_d       = '0;
                tap_d       = 3'd0;
                sat_d       = sat_q | clamp_s;
                if (sec_q == LAST_SEC) begin
                    out_data_d = y_s;
                    state_d    = OUT;
                end else begin
                    sec_d   = sec_q + SEC_W'(1'b1);
                    state_d = MAC;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register bank; reset restores pass-through coefficients and drops any in-flight sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            tap_q      <= 3'd0;
            acc_q      <= '0;
            cur_x_q    <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                coef_q[i] <= ((i % 5) == 0) ? B0_ONE : '0;
            end
            for (int s = 0; s < N_SECT; s++) begin
                x1_q[s] <= '0;
                x2_q[s] <= '0;
                y1_q[s] <= '0;
                y2_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            cur_x_q    <= cur_x_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            coef_q     <= coef_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end
endmodule

// File: tb/tb_iir_lp_cascade.sv
// Self-checking bench for iir_lp_cascade: arithmetic biquad-cascade model, directed cases and random traffic.
module tb_iir_lp_cascade;
    localparam int DW = 16;
    localparam int CW = 18;
    localparam int NS = 3;
    localparam int AW = $clog2(5*NS);
`ifdef IIR_LP_SAT_EN
    localparam longint SAT_LIT = 32767;
    localparam longint SAT_EXP = 1;
`else
    localparam longint SAT_LIT = -30814;
    localparam longint SAT_EXP = 0;
`endif

    logic          clk = 1'b0, rst = 1'b0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic          coef_we = 1'b0, clear_hist = 1'b0, sat_flag;
    logic [DW-1:0] in_data = '0, out_data;
    logic [AW-1:0] coef_addr = '0;
    logic [CW-1:0] coef_wdata = '0;

    iir_lp_cascade #(.DATA_W(DW), .COEF_W(CW), .N_SECT(NS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .clear_hist(clear_hist), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int     checks = 0, errors = 0;
    longint coefm [5*NS];
    longint x1m [NS], x2m [NS], y1m [NS], y2m [NS];
    bit     satm = 1'b0;
    longint exp_q [$];
    time    acc_time = 0, t_hs = 0;
    bit     force_low = 1'b0, bp_mode = 1'b0, prev_ov = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint narrow(input longint acc);
        longint        t;
        logic [DW-1:0] w;
        t = (acc + 32768) >>> 16;
`ifdef IIR_LP_SAT_EN
        if (t > 32767) begin t = 32767; satm = 1'b1; end
        else if (t < -32768) begin t = -32768; satm = 1'b1; end
`else
        w = t[DW-1:0];
        t = longint'($signed(w));
`endif
        return t;
    endfunction

    function automatic longint run_model(input longint xin);
        longint x, acc, y;
        x = xin;
        for (int s = 0; s < NS; s++) begin
            acc = coefm[s*5]*x + coefm[s*5+1]*x1m[s] + coefm[s*5+2]*x2m[s]
                - coefm[s*5+3]*y1m[s] - coefm[s*5+4]*y2m[s];
            y = narrow(acc);
            x2m[s] = x1m[s]; x1m[s] = x; y2m[s] = y1m[s]; y1m[s] = y;
            x = y;
        end
        return x;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            x1m[s] = 0; x2m[s] = 0; y1m[s] = 0; y2m[s] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 5*NS; i++) coefm[i] = ((i % 5) == 0) ? 65536 : 0;
        clear_model();
        satm = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_in_ready_during", in_ready, 1);
        check("rst_out_valid_during", out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", longint'($signed(out_data)), 0);
        check("rst_sat_flag", sat_flag, 0);
    endtask

    task automatic wr_coef(input int addr, input longint val);
        coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = val[CW-1:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
        coefm[addr] = val;
    endtask

    task automatic wait_out();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) check("out_timeout_pending", exp_q.size(), 0);
    endtask

    task automatic send(input longint v, input bit clr, input bit pin, input longint lit, input bit wait_done);
        int     n = 0;
        longint e;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check("in_ready_timeout", n, 0);
        in_valid = 1'b1; in_data = v[DW-1:0]; clear_hist = clr;
        @(posedge clk);
        acc_time = $time;
        if (clr) clear_model();
        e = run_model(v);
        exp_q.push_back(e);
        if (pin) check("model_literal", e, lit);
        #1;
        in_valid = 1'b0; clear_hist = 1'b0; in_data = '0;
        if (wait_done) wait_out();
    endtask

    // Sink: always ready, held low, or randomly stalling.
    initial forever begin
        @(posedge clk); #2;
        out_ready = force_low ? 1'b0 : (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Compare process: every cycle out_valid is high, check data, latency, stall behaviour and sat_flag.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_ov) check("latency", longint'(($time - acc_time - 5) / 10), 6*NS);
                check("in_ready_while_out", in_ready, 0);
                if (exp_q.size() == 0) begin
                    check("out_without_sample", exp_q.size(), 1);
                end else begin
                    check("out_data", longint'($signed(out_data)), exp_q[0]);
                    check("sat_flag", sat_flag, satm);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        @(posedge clk); #1;
        do_reset();

        send(1000, 0, 1, 1000, 1);
        send(-32768, 0, 1, -32768, 1);
        send(32767, 0, 1, 32767, 1);

        wr_coef(0, 16384); wr_coef(1, 16384); wr_coef(2, 16384);
        send(16384, 1, 1, 4096, 1);
        send(0, 0, 1, 4096, 1);
        send(0, 0, 1, 4096, 1);
        send(0, 0, 1, 0, 1);

        wr_coef(0, 32768); wr_coef(1, 0); wr_coef(2, 0); wr_coef(3, -32768);
        send(1000, 1, 1, 500, 1);
        send(1000, 0, 1, 750, 1);
        send(1000, 0, 1, 875, 1);
        send(1000, 0, 1, 938, 1);
        for (int i = 0; i < 6; i++) send(1000, 0, 0, 0, 1);

        force_low = 1'b1;
        send(-2500, 0, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("hold_out_valid", out_valid, 1);
        repeat (10) begin @(posedge clk); #1; check("hold_in_ready", in_ready, 0); end
        force_low = 1'b0;
        wait_out();
        t_hs = $time - 1;
        check("hs_in_ready", in_ready, 1);
        check("hs_out_valid", out_valid, 0);
        send(100, 0, 0, 0, 1);
        check("accept_after_hs", longint'((acc_time - t_hs) / 10), 1);

        do_reset();
        wr_coef(0, 124518); wr_coef(5, 124518); wr_coef(10, 124518);
        send(30000, 1, 1, SAT_LIT, 1);
        check("sat_flag_literal", sat_flag, SAT_EXP);

        do_reset();
        send(777, 0, 1, 777, 0);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = AW'(0); coef_wdata = 18'sd32768;
        @(posedge clk); #1;
        coef_we = 1'b0;
        wait_out();
        send(500, 0, 1, 500, 1);

        in_valid = 1'b1; in_data = 16'sd999;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("mid_mac_in_ready", in_ready, 0);
        coef_we = 1'b1; coef_addr = AW'(5); coef_wdata = 18'sd0;
        @(posedge clk); #1;
        coef_we = 1'b0;
        do_reset();
        send(1234, 0, 1, 1234, 1);
        send(-4321, 0, 1, -4321, 1);

        do_reset();
        bp_mode = 1'b1;
        for (int a = 0; a < 5*NS; a++) wr_coef(a, longint'($urandom_range(0, 80000)) - 40000);
        for (int i = 0; i < 30; i++) begin
            send(longint'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 9) == 0), 0, 0, 0);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_out();
        bp_mode = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
